dffram_mp: RTL

//  Parametrised multi-read-port flop RAM, successor to the single-read DFF RAM.
//  One byte-masked write port with read-before-write readback, NRD independent

---
 rtl/dffram_mp_if.sv | 28 ++
 rtl/dffram_mp.sv | 118 +++++++++++
 2 files changed

// File: rtl/dffram_mp_if.sv
// Bus bundle for dffram_mp: clear control, byte-masked write port and NRD read ports.
interface dffram_mp_if #(
  parameter int DWIDTH = 24,
  parameter int AWIDTH = 6,
  parameter int NRD    = 2
);
  logic                   clr;
  logic                   busy;
  logic                   we;
  logic [DWIDTH/8-1:0]    wmask;
  logic [AWIDTH-1:0]      adr_w;
  logic [DWIDTH-1:0]      dat_i;
  logic [DWIDTH-1:0]      dat_o;
  logic [NRD-1:0]         re;
  logic [NRD*AWIDTH-1:0]  adr_r;
  logic [NRD*DWIDTH-1:0]  dat_r;
  logic [NRD-1:0]         rd_valid;

  modport master (
    output clr, we, wmask, adr_w, dat_i, re, adr_r,
    input  busy, dat_o, dat_r, rd_valid
  );

  modport slave (
    input  clr, we, wmask, adr_w, dat_i, re, adr_r,
    output busy, dat_o, dat_r, rd_valid
  );
endinterface

// File: rtl/dffram_mp.sv
// Multi-read-port flop RAM with byte-masked write, read-before-write readback and clear sweep.
// Define DFFRAM_BYPASS_EN for write-first forwarding on same-cycle read/write hits.
//
// state | meaning
// CLEAR | sweep zeroes word ptr each cycle; write/read ports ignored, busy=1
// IDLE  | normal operation
module dffram_mp #(
  parameter int DWIDTH = 24,
  parameter int AWIDTH = 6,
  parameter int DEPTH  = 64,
  parameter int NRD    = 2
) (
  input logic        clk,
  input logic        rst_n,
  dffram_mp_if.slave bus
);
  localparam int NB = DWIDTH / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   ptr_q, ptr_d;
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [DWIDTH-1:0]   wr_old, wr_new;
  logic                wr_ok;
  logic [DWIDTH-1:0]   rd_word [NRD];
  logic [DWIDTH-1:0]   dat_o_q;
  logic [NRD*DWIDTH-1:0] dat_r_q;
  logic [NRD-1:0]      vld_q;

  function automatic logic in_range(input logic [AWIDTH-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (bus.clr) begin
          ptr_d = '0;
        end else if (ptr_q == AWIDTH'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AWIDTH'(1);
        end
      end
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign bus.busy = (state_q == CLEAR);

  // Merged word is shared by the array update and the optional forwarding path.
  always_comb begin
    wr_old = in_range(bus.adr_w) ? mem[bus.adr_w] : '0;
    wr_new = wr_old;
    for (int k = 0; k < NB; k++) begin
      if (bus.wmask[k]) wr_new[8*k +: 8] = bus.dat_i[8*k +: 8];
    end
    wr_ok = rst_n && (state_q == IDLE) && bus.we && in_range(bus.adr_w);
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_word[i] = in_range(bus.adr_r[i*AWIDTH +: AWIDTH]) ?
                   mem[bus.adr_r[i*AWIDTH +: AWIDTH]] : '0;
`ifdef DFFRAM_BYPASS_EN
      if (wr_ok && (bus.adr_r[i*AWIDTH +: AWIDTH] == bus.adr_w)) rd_word[i] = wr_new;
`endif
    end
  end

  // Storage has no reset; the sweep is what guarantees zero contents.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == CLEAR)) begin
      mem[ptr_q] <= '0;
    end else if (wr_ok) begin
      mem[bus.adr_w] <= wr_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      dat_o_q <= '0;
      dat_r_q <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == IDLE) begin
        dat_o_q <= wr_old;
        vld_q   <= bus.re;
        for (int i = 0; i < NRD; i++) begin
          if (bus.re[i]) dat_r_q[i*DWIDTH +: DWIDTH] <= rd_word[i];
        end
      end else begin
        vld_q <= '0;
      end
    end
  end

  assign bus.dat_o    = dat_o_q;
  assign bus.dat_r    = dat_r_q;
  assign bus.rd_valid = vld_q;
endmodule
